// File: rtl/micro_switch_pkg.sv
// Shared micro-switch NoC definitions: route commands used by merge and distribute switches.
package micro_switch_pkg;

    localparam logic [1:0] CMD_NA          = 2'b00;
    localparam logic [1:0] CMD_BRANCH_LOW  = 2'b01;
    localparam logic [1:0] CMD_BRANCH_HIGH = 2'b10;
    localparam logic [1:0] CMD_DUPLICATE   = 2'b11;

    localparam int NUM_BRANCHES = 2;
    localparam logic [1:0] FIFO_FULL_COUNT = 2'd2;

    // Target mask bit 0 = low branch, bit 1 = high branch.
    function automatic logic [NUM_BRANCHES-1:0] cmd_to_mask(input logic [1:0] cmd);
        logic [NUM_BRANCHES-1:0] mask;
        unique case (cmd)
            CMD_BRANCH_LOW:  mask = 2'b01;
            CMD_BRANCH_HIGH: mask = 2'b10;
            CMD_DUPLICATE:   mask = 2'b11;
            default:         mask = 2'b00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/fifo_seq_2entry.sv
// Two-entry FIFO with head visible combinationally; writes to a full FIFO and
// reads from an empty one are ignored.
module fifo_seq_2entry
    import micro_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_reg [0:1];
    logic                  wr_ptr_reg, wr_ptr_next;
    logic                  rd_ptr_reg, rd_ptr_next;
    logic [1:0]            count_reg, count_next;
    logic                  wr_ok, rd_ok;

    assign wr_ok = wr_en && (count_reg != FIFO_FULL_COUNT);
    assign rd_ok = rd_en && (count_reg != 2'd0);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_ok) wr_ptr_next = ~wr_ptr_reg;
        if (rd_ok) rd_ptr_next = ~rd_ptr_reg;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: contents are only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_reg[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/distribute_switch_seq.sv
// 1-to-2 distribute switch with a 2-entry buffer per branch.
// Optional feature: DISTRIBUTE_SWITCH_DROP_CNT_EN adds a saturating o_drop_cnt for dropped (cmd 00) words.
module distribute_switch_seq
    import micro_switch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data_bus,
    output logic                    o_ready,
    input  logic                    i_en,
    input  logic [1:0]              i_cmd,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
`ifdef DISTRIBUTE_SWITCH_DROP_CNT_EN
    output logic [15:0]             o_drop_cnt,
`endif
    input  logic [1:0]              i_ready
);

    logic [NUM_BRANCHES-1:0] target;
    logic [NUM_BRANCHES-1:0] branch_full;
    logic                    accept;

    assign target  = cmd_to_mask(i_cmd);
    // Ready looks only at registered counts, so no ready-to-ready combinational path exists.
    assign o_ready = i_en && ((target & branch_full) == '0);
    assign accept  = i_valid && o_ready;

    generate
        for (genvar gi = 0; gi < NUM_BRANCHES; gi++) begin : g_branch
            logic [DATA_WIDTH-1:0] head;
            logic [1:0]            count;
            logic                  pop;

            assign pop = o_valid[gi] && i_ready[gi];

            fifo_seq_2entry #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (accept && target[gi]),
                .wr_data (i_data_bus),
                .rd_en   (pop),
                .rd_data (head),
                .count   (count)
            );

            assign branch_full[gi] = (count == FIFO_FULL_COUNT);
            assign o_valid[gi]     = (count != 2'd0);
            assign o_data_bus[gi*DATA_WIDTH +: DATA_WIDTH] = o_valid[gi] ? head : '0;
        end
    endgenerate

`ifdef DISTRIBUTE_SWITCH_DROP_CNT_EN
    logic [15:0] drop_cnt_reg, drop_cnt_next;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (accept && (i_cmd == CMD_NA) && (drop_cnt_reg != 16'hFFFF))
            drop_cnt_next = drop_cnt_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_reg <= 16'd0;
        else     drop_cnt_reg <= drop_cnt_next;
    end

    assign o_drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_distribute_switch_seq.sv
// Directed self-checking bench for distribute_switch_seq.
module tb_distribute_switch_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic          o_ready;
    logic          i_en;
    logic [1:0]    i_cmd;
    logic [1:0]    o_valid;
    logic [2*DW-1:0] o_data_bus;
    logic [1:0]    i_ready;
`ifdef DISTRIBUTE_SWITCH_DROP_CNT_EN
    logic [15:0]   o_drop_cnt;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    distribute_switch_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
`ifdef DISTRIBUTE_SWITCH_DROP_CNT_EN
        .o_drop_cnt (o_drop_cnt),
`endif
        .i_ready    (i_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [DW-1:0] d);
        i_valid    = v;
        i_cmd      = c;
        i_data_bus = d;
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b1; i_ready = 2'b00;
        drive(1'b0, 2'b00, '0);
        step(); step();
        rst = 1'b0;
        #1;
        check_eq("reset_valid", {62'd0, o_valid}, 64'd0);
        check_eq("reset_data", o_data_bus, 64'd0);
        check_eq("reset_ready", {63'd0, o_ready}, 64'd1);
        i_en = 1'b0; #1;
        check_eq("en_low_ready", {63'd0, o_ready}, 64'd0);
        i_en = 1'b1;

        // Single word to low branch
        i_ready = 2'b11;
        drive(1'b1, 2'b01, 32'hA5A5_0001);
        step();
        drive(1'b0, 2'b00, '0);
        check_eq("low_valid", {62'd0, o_valid}, 64'd1);
        check_eq("low_data", o_data_bus, {32'h0, 32'hA5A5_0001});
        step();
        check_eq("low_drained", {62'd0, o_valid}, 64'd0);

        // Duplicate
        drive(1'b1, 2'b11, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 2'b00, '0);
        check_eq("dup_valid", {62'd0, o_valid}, 64'd3);
        check_eq("dup_data", o_data_bus, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        step();
        check_eq("dup_popped", {62'd0, o_valid}, 64'd0);

        // High branch backpressure
        i_ready = 2'b01;
        drive(1'b1, 2'b10, 32'd1); step();
        drive(1'b1, 2'b10, 32'd2); step();
        drive(1'b1, 2'b10, 32'd3); #1;
        check_eq("high_full_ready", {63'd0, o_ready}, 64'd0);
        step();
        check_eq("high_full_valid", {62'd0, o_valid}, 64'd2);
        check_eq("high_head1", o_data_bus, {32'd1, 32'd0});
        i_ready = 2'b11;
        step();
        i_ready = 2'b01; #1;
        check_eq("high_ready_again", {63'd0, o_ready}, 64'd1);
        check_eq("high_head2", o_data_bus, {32'd2, 32'd0});
        step();
        drive(1'b0, 2'b00, '0);
        check_eq("high_head2_hold", o_data_bus, {32'd2, 32'd0});
        i_ready = 2'b11;
        step();
        check_eq("high_head3", o_data_bus, {32'd3, 32'd0});
        step();
        check_eq("high_drained", {62'd0, o_valid}, 64'd0);

        // Duplicate blocked by full high branch; low-only still accepted
        i_ready = 2'b00;
        drive(1'b1, 2'b10, 32'h10); step();
        drive(1'b1, 2'b10, 32'h11); step();
        drive(1'b1, 2'b11, 32'h20); #1;
        check_eq("dup_blocked_ready", {63'd0, o_ready}, 64'd0);
        step();
        check_eq("dup_blocked_valid", {62'd0, o_valid}, 64'd2);
        drive(1'b1, 2'b01, 32'h21); #1;
        check_eq("low_ok_ready", {63'd0, o_ready}, 64'd1);
        step();
        drive(1'b1, 2'b01, 32'h22);
        check_eq("mixed_valid", {62'd0, o_valid}, 64'd3);
        check_eq("mixed_data", o_data_bus, {32'h10, 32'h21});
        step();
        drive(1'b0, 2'b00, '0);
        check_eq("low_full_head", o_data_bus, {32'h10, 32'h21});

        // Reset with buffered words
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        check_eq("midrst_valid", {62'd0, o_valid}, 64'd0);
        check_eq("midrst_data", o_data_bus, 64'd0);
        check_eq("midrst_ready", {63'd0, o_ready}, 64'd1);

        // Streaming through low with simultaneous enqueue/dequeue
        i_ready = 2'b11;
        drive(1'b1, 2'b01, 32'h100); step();
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 2'b01, 32'h100 + k);
            check_eq("stream_ready", {63'd0, o_ready}, 64'd1);
            check_eq("stream_data", o_data_bus, {32'd0, 32'h100 + k - 1});
            step();
        end
        drive(1'b0, 2'b00, '0);
        check_eq("stream_last", o_data_bus, {32'd0, 32'h103});
        step();

        // Dropped words and disabled switch
        i_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b00, 32'h300 + k);
            check_eq("drop_ready", {63'd0, o_ready}, 64'd1);
            step();
        end
        drive(1'b0, 2'b00, '0);
        check_eq("drop_valid", {62'd0, o_valid}, 64'd0);
`ifdef DISTRIBUTE_SWITCH_DROP_CNT_EN
        check_eq("drop_cnt", {48'd0, o_drop_cnt}, 64'd3);
`endif
        i_en = 1'b0;
        drive(1'b1, 2'b01, 32'h400);
        step();
        check_eq("disabled_no_accept", {62'd0, o_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
